// File: rtl/exu_bp_stat_ctr.sv
// Branch-prediction statistics unit for the EXU.
// Seven event counters are fed by NUM_CH branch channels. The counters are
// copied into shadow registers on snap. Reads return the shadow copies, or the
// sticky overflow flags when rd_sel is 7.
module exu_bp_stat_ctr #(
    parameter int CNT_W  = 32,
    parameter int NUM_CH = 2,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic [NUM_CH-1:0] ev_valid,
    input  logic [NUM_CH-1:0] ev_flush,
    input  logic [NUM_CH-1:0] ev_pred_t,
    input  logic [NUM_CH-1:0] ev_pred_nt,
    input  logic [NUM_CH-1:0] ev_misp,
    input  logic [NUM_CH-1:0] ev_cond_misp,
    input  logic [NUM_CH-1:0] ev_tgt_misp,
    input  logic              clr,
    input  logic              snap,
    input  logic              rd_en,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic [6:0]        ovf
);

    localparam int NUM_CTR = 7;
    localparam int SUM_W   = CNT_W + 3;

    logic [NUM_CH-1:0] qual;
    logic [NUM_CH-1:0] term [NUM_CTR];
    logic [2:0]        inc  [NUM_CTR];
    logic [SUM_W-1:0]  sum  [NUM_CTR];

    logic [CNT_W-1:0]  cnt_q    [NUM_CTR];
    logic [CNT_W-1:0]  cnt_d    [NUM_CTR];
    logic [CNT_W-1:0]  shadow_q [NUM_CTR];
    logic [CNT_W-1:0]  shadow_d [NUM_CTR];
    logic [6:0]        ovf_q;
    logic [6:0]        ovf_d;
    logic [CNT_W-1:0]  rd_data_q;
    logic [CNT_W-1:0]  rd_data_d;
    logic              rd_valid_q;
    logic              rd_valid_d;

    // Qualify each channel, build the per-counter event terms and popcount them
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            qual[c] = ev_valid[c] & (ev_pred_t[c] | ev_pred_nt[c]) & ~ev_flush[c] & ~freeze;
        end
        term[0] = qual;
        term[1] = qual & ~ev_misp;
        term[2] = qual & ev_misp;
        term[3] = qual & ev_cond_misp;
        term[4] = qual & ev_tgt_misp;
        term[5] = qual & ev_pred_t;
        term[6] = qual & ev_pred_nt;
        for (int i = 0; i < NUM_CTR; i++) begin
            inc[i] = 3'd0;
            for (int c = 0; c < NUM_CH; c++) begin
                inc[i] = inc[i] + {2'b00, term[i][c]};
            end
        end
    end

    // Next counter and overflow state: clear wins, otherwise add with saturate or wrap
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_CTR; i++) begin
            sum[i]   = {3'b000, cnt_q[i]} + {{(SUM_W-3){1'b0}}, inc[i]};
            cnt_d[i] = sum[i][CNT_W-1:0];
            if (clr) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (|sum[i][SUM_W-1:CNT_W]) begin
                ovf_d[i] = 1'b1;
                if (SAT != 0) begin
                    cnt_d[i] = '1;
                end
            end
        end
    end

    // Shadow capture and registered read path, both using pre-update values
    always_comb begin
        for (int i = 0; i < NUM_CTR; i++) begin
            shadow_d[i] = snap ? cnt_q[i] : shadow_q[i];
        end
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            if (rd_sel == 3'd7) begin
                rd_data_d = {{(CNT_W-7){1'b0}}, ovf_q};
            end else begin
                rd_data_d = shadow_q[rd_sel];
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTR; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
            ovf_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CTR; i++) begin
                cnt_q[i]    <= cnt_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ovf      = ovf_q;

endmodule
